// File: rtl/fpnew_pkg.sv
// Shared floating-point types used by the FPU scheduling blocks.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_divsqrt_lane_sched.sv
// Dispatches div/sqrt ops round-robin over iterative lanes and retires
// their results in dispatch order, NaN-boxing each result to its format.
module fpnew_divsqrt_lane_sched
    import fpnew_pkg::*;
#(
    parameter int unsigned NumLanes = 2,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned TagWidth = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [1:0][WIDTH-1:0]              operands_i,
    input  roundmode_e                         rnd_mode_i,
    input  operation_e                         op_i,
    input  fp_format_e                         dst_fmt_i,
    input  logic [TagWidth-1:0]                tag_i,
    input  logic                               mask_i,
    output logic [NumLanes-1:0]                lane_start_o,
    output logic [1:0][WIDTH-1:0]              lane_operands_o,
    output roundmode_e                         lane_rnd_mode_o,
    output operation_e                         lane_op_o,
    output fp_format_e                         lane_fmt_o,
    input  logic [NumLanes-1:0]                lane_ready_i,
    input  logic [NumLanes-1:0]                lane_done_i,
    input  logic [NumLanes-1:0][WIDTH-1:0]     lane_result_i,
    input  status_t [NumLanes-1:0]             lane_status_i,
    output logic                               lane_flush_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [WIDTH-1:0]                   result_o,
    output status_t                            status_o,
    output logic [TagWidth-1:0]                tag_o,
    output logic                               mask_o,
    input  logic                               flush_i,
    output logic                               busy_o
);

    localparam int unsigned PtrW = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} slot_state_e;

    slot_state_e         r_state    [NumLanes];
    slot_state_e         w_state_nxt[NumLanes];
    logic [PtrW-1:0]     r_dptr;
    logic [PtrW-1:0]     r_rptr;
    logic [TagWidth-1:0] r_tag      [NumLanes];
    logic                r_mask     [NumLanes];
    fp_format_e          r_fmt      [NumLanes];
    logic [WIDTH-1:0]    r_result   [NumLanes];
    status_t             r_status   [NumLanes];

    logic                w_accept;
    logic                w_retire;
    logic [NumLanes-1:0] w_done_cap;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumLanes - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Boxing is applied at capture so the held register is already final.
    function automatic logic [WIDTH-1:0] nan_box(input logic [WIDTH-1:0] v,
                                                 input fp_format_e        f);
        logic [WIDTH-1:0] boxed;
        int unsigned      pos;
        case (f)
            FP32:          pos = 32;
            FP16, FP16ALT: pos = 16;
            default:       pos = WIDTH;
        endcase
        for (int unsigned b = 0; b < WIDTH; b++) begin
            boxed[b] = (b >= pos) ? 1'b1 : v[b];
        end
        return boxed;
    endfunction

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumLanes; i++) r_state[i] <= IDLE;
        end else begin
            for (int i = 0; i < NumLanes; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    // Next-state logic per slot
    always_comb begin
        for (int i = 0; i < NumLanes; i++) begin
            w_state_nxt[i] = r_state[i];
            if (flush_i) begin
                w_state_nxt[i] = IDLE;
            end else begin
                case (r_state[i])
                    IDLE:    if (w_accept && r_dptr == PtrW'(i))   w_state_nxt[i] = BUSY;
                    BUSY:    if (lane_done_i[i])                   w_state_nxt[i] = HOLD;
                    HOLD:    if (w_retire && r_rptr == PtrW'(i))   w_state_nxt[i] = IDLE;
                    default:                                       w_state_nxt[i] = IDLE;
                endcase
            end
        end
    end

    // Handshakes, lane broadcast and in-order output selection
    always_comb begin
        in_ready_o      = rst_ni && (r_state[r_dptr] == IDLE) && lane_ready_i[r_dptr] && !flush_i;
        w_accept        = in_valid_i && in_ready_o;
        lane_start_o    = '0;
        if (w_accept) lane_start_o[r_dptr] = 1'b1;
        lane_operands_o = operands_i;
        lane_rnd_mode_o = rnd_mode_i;
        lane_op_o       = op_i;
        lane_fmt_o      = dst_fmt_i;
        lane_flush_o    = flush_i;
        out_valid_o     = (r_state[r_rptr] == HOLD);
        w_retire        = out_valid_o && out_ready_i;
        result_o        = r_result[r_rptr];
        status_o        = r_status[r_rptr];
        tag_o           = r_tag[r_rptr];
        mask_o          = r_mask[r_rptr];
        busy_o          = 1'b0;
        w_done_cap      = '0;
        for (int i = 0; i < NumLanes; i++) begin
            if (r_state[i] != IDLE) busy_o = 1'b1;
            w_done_cap[i] = !flush_i && lane_done_i[i] && (r_state[i] == BUSY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_dptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_accept) r_dptr <= ptr_inc(r_dptr);
            if (w_retire) r_rptr <= ptr_inc(r_rptr);
        end
    end

    // Slot payload capture: metadata at dispatch, result at lane completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumLanes; i++) begin
                r_tag[i]    <= '0;
                r_mask[i]   <= 1'b0;
                r_fmt[i]    <= FP32;
                r_result[i] <= '0;
                r_status[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumLanes; i++) begin
                if (w_accept && r_dptr == PtrW'(i)) begin
                    r_tag[i]  <= tag_i;
                    r_mask[i] <= mask_i;
                    r_fmt[i]  <= dst_fmt_i;
                end
                if (w_done_cap[i]) begin
                    r_result[i] <= nan_box(lane_result_i[i], r_fmt[i]);
                    r_status[i] <= lane_status_i[i];
                end
            end
        end
    end

endmodule

// File: doc/fpnew_divsqrt_lane_sched.md
FPNEW_DIVSQRT_LANE_SCHED -- requirements
Module: fpnew_divsqrt_lane_sched

Interface
REQ-001 Parameter NumLanes, default 2: number of iterative div/sqrt lanes served; legal range 1..8.
REQ-002 Parameter WIDTH, default 64: operand/result width; legal values 16, 32, 64.
REQ-003 Parameter TagWidth, default 4: width of the per-operation tag.
REQ-004 Ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  input accept.
- operands_i  in  2xWIDTH  operands.
- rnd_mode_i  in  fpnew_pkg::roundmode_e  rounding mode.
- op_i  in  fpnew_pkg::operation_e  DIV selects divide; any other value selects sqrt.
- dst_fmt_i  in  fpnew_pkg::fp_format_e  destination format.
- tag_i  in  TagWidth  operation tag.
- mask_i  in  1  lane mask.
- lane_start_o  out  NumLanes  one-hot start pulse.
- lane_operands_o, lane_rnd_mode_o, lane_op_o, lane_fmt_o  out  as inputs  broadcast to all lanes.
- lane_ready_i  in  NumLanes  lane not busy.
- lane_done_i  in  NumLanes  lane result valid, one-cycle pulse.
- lane_result_i  in  NumLanes x WIDTH  lane results.
- lane_status_i  in  NumLanes x fpnew_pkg::status_t  lane flags.
- lane_flush_o  out  1  flush to lanes.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result accept.
- result_o  out  WIDTH  result.
- status_o  out  fpnew_pkg::status_t  status flags.
- tag_o  out  TagWidth  tag.
- mask_o  out  1  mask.
- flush_i  in  1  synchronous flush.
- busy_o  out  1  any lane occupied.

Function
REQ-005 Each lane slot SHALL have an FSM with states IDLE, BUSY and HOLD.
REQ-006 FSM transitions:
- IDLE->BUSY on dispatch.
- BUSY->HOLD on lane_done_i.
- HOLD->IDLE on the output handshake out_valid_o&&out_ready_i.
REQ-007 Dispatch pointer dptr and retire pointer rptr SHALL each be ceil(log2(NumLanes)) bits (1-bit register when NumLanes=1), reset to 0, and increment by 1, wrapping from NumLanes-1 to 0.
REQ-008 in_ready_o SHALL be (slot[dptr]==IDLE) && lane_ready_i[dptr] && !flush_i, combinationally.
REQ-009 On in_valid_i&&in_ready_o:
- lane_start_o[dptr] pulses high for exactly that cycle.
- tag, mask and dst_fmt are captured into slot dptr.
- dptr advances.
REQ-010 lane_operands_o, lane_rnd_mode_o, lane_op_o and lane_fmt_o SHALL be combinational copies of the input-side signals.
REQ-011 On lane_done_i[i] with slot i BUSY, the slot SHALL capture lane_result_i[i] and lane_status_i[i] at the clock edge. lane_done_i[i] with slot i not BUSY SHALL be ignored.
REQ-012 out_valid_o SHALL be (slot[rptr]==HOLD). result_o, status_o, tag_o and mask_o SHALL come from the slot[rptr] registers, with no bypass. Minimum latency is lane_done_i -> out_valid_o in the next cycle.
REQ-013 Results SHALL retire strictly in dispatch order, regardless of the order in which lanes complete.
REQ-014 While out_valid_o && !out_ready_i, all output signals SHALL stay stable.
REQ-015 On the output handshake, rptr SHALL advance. The freed slot SHALL be dispatchable no earlier than the next cycle.
REQ-016 result_o SHALL be NaN-boxed according to the captured format:
- FP32: bits above 31 forced to 1.
- FP16 and FP16ALT: bits above 15 forced to 1.
- FP64: passed unchanged.
- Any boxing position at or above WIDTH: no effect.
REQ-017 flush_i SHALL:
- drive lane_flush_o high combinationally.
- move all slots to IDLE and set dptr and rptr to 0 at the next edge.
- cause lane_done_i in the same cycle to be ignored.
- give out_valid_o=0 in the following cycle.
REQ-018 busy_o SHALL be 1 whenever any slot is not IDLE.
REQ-019 At most NumLanes operations SHALL be in flight. A full pipe blocks input through REQ-008.

Reset
REQ-020 While rst_ni=0:
- all slots are IDLE; dptr=rptr=0.
- all capture registers are 0.
- out_valid_o=0, lane_start_o=0, busy_o=0.
- result_o, status_o, tag_o and mask_o are 0.
- in_ready_o=0.
REQ-021 Reset assertion mid-operation SHALL discard all in-flight operations, with no output produced.

Verification (NumLanes=2, WIDTH=64)
REQ-022 Single DIV: tag 3 accepted in cycle 0; lane_done_i[0] in cycle 10 with result 0x4000000000000000 -> out_valid_o in cycle 11, result_o=0x4000000000000000, tag_o=3.
REQ-023 Reordering: tags 1 and 2 dispatched in cycles 0 and 1; lane 1 done in cycle 5, lane 0 done in cycle 8; out_ready_i=1 -> tag 1 output in cycle 9, tag 2 output in cycle 10.
REQ-024 Full: both slots BUSY and in_valid_i=1 -> in_ready_o=0 and lane_start_o=0 until the first retire plus 1 cycle.
REQ-025 Backpressure: out_ready_i=0 for 5 cycles while in HOLD -> outputs stable, and rptr advances only on out_ready_i=1.
REQ-026 Flush: flush_i pulsed with both slots BUSY and lane_done_i[0] in the same cycle -> no output, busy_o=0 and in_ready_o=lane_ready_i[0] in the next cycle.
REQ-027 NaN-box: FP32 op with lane_result_i=0x000000003F800000 -> result_o=0xFFFFFFFF3F800000.
